// File: rtl/fetch_pc_pipeline.sv
// -----------------------------------------------------------------------------
// fetch_pc_pipeline
//   Owns the fetch PC and carries each fetched PC and its branch prediction from
//   IF (stage 1) through ID (stage 2) to EX (stage 3). The BTB sits directly
//   downstream: it sees instruction_pc_1/instruction_pc_3/prev_taken_3 and
//   returns the next PC, a mispredict flush and a prediction for the IF PC.
//   Wrong-path slots are squashed on flush. Memory stalls freeze everything, and
//   hazard stalls hold IF/ID while inserting a bubble into EX. Two saturating
//   counters track resolved branches and mispredicts.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   memory_stall        global freeze (highest priority after reset)
//   hazard_stall        hold IF/ID, bubble into EX
//   btb_branch_pc       next fetch PC (predicted or corrected)
//   btb_flush           stage-3 branch was mispredicted
//   btb_taken           prediction for the current IF PC
//   is_branch_3         EX-slot instruction is a branch
//   cnt_clear           synchronous clear of both counters
//   instruction_pc_1    current fetch PC
//   instruction_pc_2    ID-slot PC,  valid_2 marks a real instruction
//   instruction_pc_3    EX-slot PC,  valid_3 marks a real instruction
//   prev_taken_3        prediction carried with the EX slot (0 for bubbles)
//   branch_cnt          resolved branch count (saturating)
//   mispredict_cnt      flush count (saturating)
// -----------------------------------------------------------------------------
module fetch_pc_pipeline #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memory_stall,
    input  logic             hazard_stall,
    input  logic [31:0]      btb_branch_pc,
    input  logic             btb_flush,
    input  logic             btb_taken,
    input  logic             is_branch_3,
    input  logic             cnt_clear,
    output logic [31:0]      instruction_pc_1,
    output logic [31:0]      instruction_pc_2,
    output logic             valid_2,
    output logic [31:0]      instruction_pc_3,
    output logic             valid_3,
    output logic             prev_taken_3,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [31:0]      pc_p0;
    logic [31:0]      pc_p1;
    logic             taken_p1;
    logic             vld_p1;
    logic [31:0]      pc_p2;
    logic             taken_p2;
    logic             vld_p2;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispredict_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Stage 1 (IF) fetch PC, stage 2 (ID) and stage 3 (EX) slots
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_p0    <= RESET_PC;
            pc_p1    <= '0;
            taken_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            pc_p2    <= '0;
            taken_p2 <= 1'b0;
            vld_p2   <= 1'b0;
        end else if (memory_stall) begin
            // Full freeze; a pending flush is re-reported by the BTB afterwards
            // because the EX slot it resolves against is held too.
        end else if (btb_flush) begin
            // Redirect and squash both younger slots; pc fields are left as-is
            // since nothing downstream looks at a bubble's PC.
            pc_p0    <= btb_branch_pc;
            taken_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            taken_p2 <= 1'b0;
            vld_p2   <= 1'b0;
        end else if (hazard_stall) begin
            taken_p2 <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            pc_p0    <= btb_branch_pc;
            pc_p1    <= pc_p0;
            taken_p1 <= btb_taken;
            vld_p1   <= 1'b1;
            pc_p2    <= pc_p1;
            taken_p2 <= taken_p1;
            vld_p2   <= vld_p1;
        end
    end

    // Counters: clear wins over increment and also acts during a memory stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_r     <= '0;
            mispredict_cnt_r <= '0;
        end else if (cnt_clear) begin
            branch_cnt_r     <= '0;
            mispredict_cnt_r <= '0;
        end else if (!memory_stall) begin
            if (vld_p2 && is_branch_3) begin
                branch_cnt_r <= sat_inc(branch_cnt_r);
            end
            if (btb_flush) begin
                mispredict_cnt_r <= sat_inc(mispredict_cnt_r);
            end
        end
    end

    assign instruction_pc_1 = pc_p0;
    assign instruction_pc_2 = pc_p1;
    assign valid_2          = vld_p1;
    assign instruction_pc_3 = pc_p2;
    assign valid_3          = vld_p2;
    assign prev_taken_3     = taken_p2 & vld_p2;
    assign branch_cnt       = branch_cnt_r;
    assign mispredict_cnt   = mispredict_cnt_r;

endmodule

// File: tb/tb_fetch_pc_pipeline.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_pipeline
//   Directed table of cycle vectors, hand-written counter/reset sequences, and a
//   randomized run checked against a slot-level reference model.
// -----------------------------------------------------------------------------
module tb_fetch_pc_pipeline;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, memory_stall, hazard_stall;
    logic [31:0]      btb_branch_pc;
    logic             btb_flush, btb_taken, is_branch_3, cnt_clear;
    logic [31:0]      instruction_pc_1, instruction_pc_2, instruction_pc_3;
    logic             valid_2, valid_3, prev_taken_3;
    logic [CNT_W-1:0] branch_cnt, mispredict_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_pc_pipeline #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .memory_stall     (memory_stall),
        .hazard_stall     (hazard_stall),
        .btb_branch_pc    (btb_branch_pc),
        .btb_flush        (btb_flush),
        .btb_taken        (btb_taken),
        .is_branch_3      (is_branch_3),
        .cnt_clear        (cnt_clear),
        .instruction_pc_1 (instruction_pc_1),
        .instruction_pc_2 (instruction_pc_2),
        .valid_2          (valid_2),
        .instruction_pc_3 (instruction_pc_3),
        .valid_3          (valid_3),
        .prev_taken_3     (prev_taken_3),
        .branch_cnt       (branch_cnt),
        .mispredict_cnt   (mispredict_cnt)
    );

    typedef struct {
        logic        rst_n, ms, hs, fl, tk, br, clr;
        logic [31:0] bpc;
        logic [31:0] e_pc1, e_pc2;
        logic        e_v2;
        logic [31:0] e_pc3;
        logic        e_v3, e_pt3;
        int          e_bc, e_mc;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        valid;
    } slot_t;

    // Reference model state
    logic [31:0] m_pc;
    slot_t       m_id, m_ex;
    int          m_bc, m_mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, ms, hs, fl, tk, br, clr, input logic [31:0] bpc,
                       input logic [31:0] pc1, pc2, input logic v2, input logic [31:0] pc3,
                       input logic v3, pt3, input int bc, mc);
        vec_t v;
        v.rst_n = r; v.ms = ms; v.hs = hs; v.fl = fl; v.tk = tk; v.br = br; v.clr = clr;
        v.bpc = bpc; v.e_pc1 = pc1; v.e_pc2 = pc2; v.e_v2 = v2; v.e_pc3 = pc3;
        v.e_v3 = v3; v.e_pt3 = pt3; v.e_bc = bc; v.e_mc = mc;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, ms, hs, fl, tk, br, clr, input logic [31:0] bpc);
        rst_n = r; memory_stall = ms; hazard_stall = hs; btb_flush = fl;
        btb_taken = tk; is_branch_3 = br; cnt_clear = clr; btb_branch_pc = bpc;
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // One clock of the pipeline as described by its rules, on whole slots.
    task automatic model_step(input logic r, ms, hs, fl, tk, br, clr, input logic [31:0] bpc);
        if (!r) begin
            m_pc = 32'h0;
            m_id = '{32'h0, 1'b0, 1'b0};
            m_ex = '{32'h0, 1'b0, 1'b0};
            m_bc = 0;
            m_mc = 0;
            return;
        end
        if (clr) begin
            m_bc = 0;
            m_mc = 0;
        end else if (!ms) begin
            if (m_ex.valid && br) m_bc = sat(m_bc);
            if (fl) m_mc = sat(m_mc);
        end
        if (ms) begin
            // frozen
        end else if (fl) begin
            m_pc = bpc;
            m_id.valid = 1'b0; m_id.taken = 1'b0;
            m_ex.valid = 1'b0; m_ex.taken = 1'b0;
        end else if (hs) begin
            m_ex.valid = 1'b0; m_ex.taken = 1'b0;
        end else begin
            m_ex = m_id;
            m_id = '{m_pc, tk, 1'b1};
            m_pc = bpc;
        end
    endtask

    initial begin
        logic r, ms, hs, fl, tk, br, clr;
        logic [31:0] bpc;

        // r  ms hs fl tk br clr bpc          pc1           pc2           v2 pc3           v3 pt3 bc mc
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h4,       32'h4,        32'h0,        1, 32'h0,        0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h8,       32'h8,        32'h4,        1, 32'h0,        1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 32'hC,       32'hC,        32'h8,        1, 32'h4,        1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h10,      32'h10,       32'hC,        1, 32'h8,        1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, 32'h80,      32'h80,       32'h10,       1, 32'hC,        1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h84,      32'h84,       32'h80,       1, 32'h10,       1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 1, 0, 32'h14,      32'h14,       32'h0,        0, 32'h0,        0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 32'h18,      32'h18,       32'h14,       1, 32'h0,        0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 32'h1C,      32'h1C,       32'h18,       1, 32'h14,       1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 32'h20,      32'h20,       32'h1C,       1, 32'h18,       1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 32'h24,      32'h24,       32'h20,       1, 32'h1C,       1, 0, 1, 1);
        add(1, 0, 1, 0, 0, 0, 0, 32'h28,      32'h24,       32'h20,       1, 32'h0,        0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 32'h28,      32'h28,       32'h24,       1, 32'h20,       1, 0, 1, 1);
        add(1, 1, 0, 1, 0, 1, 0, 32'h100,     32'h28,       32'h24,       1, 32'h20,       1, 0, 1, 1);
        add(1, 1, 0, 1, 0, 1, 0, 32'h100,     32'h28,       32'h24,       1, 32'h20,       1, 0, 1, 1);
        add(1, 1, 0, 1, 0, 1, 0, 32'h100,     32'h28,       32'h24,       1, 32'h20,       1, 0, 1, 1);
        add(1, 0, 0, 1, 0, 1, 0, 32'h100,     32'h100,      32'h0,        0, 32'h0,        0, 0, 2, 2);
        add(1, 0, 0, 0, 0, 0, 0, 32'h104,     32'h104,      32'h100,      1, 32'h0,        0, 0, 2, 2);
        add(1, 0, 0, 0, 0, 0, 0, 32'h108,     32'h108,      32'h104,      1, 32'h100,      1, 0, 2, 2);
        add(1, 0, 1, 1, 0, 0, 0, 32'h200,     32'h200,      32'h0,        0, 32'h0,        0, 0, 2, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].ms, tbl[i].hs, tbl[i].fl, tbl[i].tk,
                  tbl[i].br, tbl[i].clr, tbl[i].bpc);
            chk($sformatf("vec%0d pc1", i), instruction_pc_1, tbl[i].e_pc1);
            chk($sformatf("vec%0d v2", i), {31'b0, valid_2}, {31'b0, tbl[i].e_v2});
            chk($sformatf("vec%0d v3", i), {31'b0, valid_3}, {31'b0, tbl[i].e_v3});
            chk($sformatf("vec%0d pt3", i), {31'b0, prev_taken_3}, {31'b0, tbl[i].e_pt3});
            if (tbl[i].e_v2 || !tbl[i].rst_n)
                chk($sformatf("vec%0d pc2", i), instruction_pc_2, tbl[i].e_pc2);
            if (tbl[i].e_v3 || !tbl[i].rst_n)
                chk($sformatf("vec%0d pc3", i), instruction_pc_3, tbl[i].e_pc3);
            chk($sformatf("vec%0d bcnt", i), 32'(branch_cnt), 32'(tbl[i].e_bc));
            chk($sformatf("vec%0d mcnt", i), 32'(mispredict_cnt), 32'(tbl[i].e_mc));
        end

        // Branch counter saturation: first EX-valid edge is the 3rd after reset.
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int k = 1; k <= 19; k++) begin
            drive(1, 0, 0, 0, 0, 1, 0, instruction_pc_1 + 32'd4);
            if (k == 16) chk("sat_bcnt14", 32'(branch_cnt), 32'd14);
            if (k == 17) chk("sat_bcnt15", 32'(branch_cnt), 32'd15);
            if (k == 19) chk("sat_bcnt_hold", 32'(branch_cnt), 32'd15);
        end
        drive(1, 0, 0, 0, 0, 1, 1, instruction_pc_1 + 32'd4);
        chk("clr_over_branch", 32'(branch_cnt), 32'd0);

        // Clear acts while frozen; the PC stays frozen.
        drive(1, 0, 0, 1, 0, 0, 0, 32'h300);
        chk("flush_mcnt", 32'(mispredict_cnt), 32'd1);
        chk("flush_pc1", instruction_pc_1, 32'h300);
        drive(1, 1, 0, 1, 0, 0, 1, 32'h400);
        chk("clr_in_stall_mcnt", 32'(mispredict_cnt), 32'd0);
        chk("clr_in_stall_pc1", instruction_pc_1, 32'h300);

        // Reset beats memory_stall and flush.
        drive(1, 0, 0, 0, 0, 0, 0, 32'h304);
        drive(1, 0, 0, 1, 0, 1, 0, 32'h500);
        chk("pre_rst_mcnt", 32'(mispredict_cnt), 32'd1);
        drive(0, 1, 0, 1, 0, 1, 0, 32'h600);
        chk("rst_pc1", instruction_pc_1, 32'h0);
        chk("rst_v2", {31'b0, valid_2}, 32'd0);
        chk("rst_v3", {31'b0, valid_3}, 32'd0);
        chk("rst_mcnt", 32'(mispredict_cnt), 32'd0);

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            r   = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            ms  = ($urandom_range(0, 7) == 0);
            hs  = ($urandom_range(0, 5) == 0);
            fl  = ($urandom_range(0, 5) == 0);
            tk  = $urandom_range(0, 1);
            br  = $urandom_range(0, 1);
            clr = ($urandom_range(0, 40) == 0);
            bpc = ($urandom_range(0, 1) == 0) ? (m_pc + 32'd4) : $urandom;
            model_step(r, ms, hs, fl, tk, br, clr, bpc);
            drive(r, ms, hs, fl, tk, br, clr, bpc);
            chk("rnd pc1", instruction_pc_1, m_pc);
            chk("rnd v2", {31'b0, valid_2}, {31'b0, m_id.valid});
            chk("rnd v3", {31'b0, valid_3}, {31'b0, m_ex.valid});
            chk("rnd pt3", {31'b0, prev_taken_3}, {31'b0, m_ex.taken & m_ex.valid});
            if (m_id.valid) chk("rnd pc2", instruction_pc_2, m_id.pc);
            if (m_ex.valid) chk("rnd pc3", instruction_pc_3, m_ex.pc);
            chk("rnd bcnt", 32'(branch_cnt), 32'(m_bc));
            chk("rnd mcnt", 32'(mispredict_cnt), 32'(m_mc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
